// File: rtl/mod_reduce_pipe.sv
// mod_reduce_pipe: 5-stage pipelined reducer of a DW-bit value mod Q with a rounded high-bit output.
// Define REDUC_RANGECHK_EN to add the err_sticky range-check flag.
module mod_reduce_pipe #(
  parameter int            QW    = 49,
  parameter logic [QW-1:0] Q     = 49'h1F41002F80001,
  parameter int            DW    = 74,
  parameter int            CHUNK = 5,
  parameter int            RW0   = 6,
  parameter int            RW1   = 8,
  parameter int            TW    = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [DW-1:0]  in_data,
  input  logic           in_mode,
  input  logic [TW-1:0]  in_tag,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [QW-1:0]  out_full,
  output logic [RW1-1:0] out_rnd,
  output logic [TW-1:0]  out_tag
`ifdef REDUC_RANGECHK_EN
  ,
  output logic           err_sticky
`endif
);
  localparam int NC = (DW - QW + CHUNK - 1) / CHUNK;
  localparam int HB = NC * CHUNK;
  localparam int SW = QW + 3;
  localparam int NT = NC + 1;
  localparam int NP = (NT + 1) / 2;
  localparam int NL = 1 << CHUNK;

  function automatic logic [QW-1:0] add_mod(input logic [QW-1:0] a, input logic [QW-1:0] b);
    logic [QW:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, Q}) s = s - {1'b0, Q};
    return s[QW-1:0];
  endfunction

  // (j * 2^(QW + k*CHUNK)) mod Q by repeated doubling, evaluated at elaboration
  function automatic logic [QW-1:0] lut_val(input int k, input int j);
    logic [QW-1:0] base;
    logic [QW-1:0] acc;
    base = QW'(1);
    for (int e = 0; e < QW + k * CHUNK; e++) base = add_mod(base, base);
    acc = '0;
    for (int b = CHUNK - 1; b >= 0; b--) begin
      acc = add_mod(acc, acc);
      if (((j >> b) & 1) != 0) acc = add_mod(acc, base);
    end
    return acc;
  endfunction

  function automatic logic [SW-1:0] mq(input int m);
    return SW'(m) * SW'(Q);
  endfunction

  function automatic logic [RW1-1:0] round_out(input logic [QW-1:0] f, input logic m);
    logic [RW0-1:0] r0;
    logic [RW1-1:0] r1;
    r0 = f[QW-1 -: RW0] + RW0'(1);
    r1 = f[QW-1 -: RW1] + RW1'(1);
    return m ? r1 : RW1'(r0);
  endfunction

  logic           w_en;
  logic           r_vld_p1, r_vld_p2, r_vld_p3, r_vld_p4, r_vld_p5;
  logic           r_mode_p1, r_mode_p2, r_mode_p3, r_mode_p4, r_mode_p5;
  logic [TW-1:0]  r_tag_p1, r_tag_p2, r_tag_p3, r_tag_p4, r_tag_p5;
  logic [QW-1:0]  w_lut [NC][NL];
  logic [HB-1:0]  w_hi;
  logic [QW-1:0]  r_lo_p1;
  logic [QW-1:0]  r_lut_p1 [NC];
  logic [QW-1:0]  w_term [2*NP];
  logic [SW-1:0]  r_ps_p2 [NP];
  logic [SW-1:0]  w_sum, r_s_p3;
  logic [QW-1:0]  w_m, r_m_p4, r_s_p4, w_full, r_full_p5;

  for (genvar k = 0; k < NC; k++) begin : g_lut
    for (genvar j = 0; j < NL; j++) begin : g_ent
      localparam logic [QW-1:0] LV = lut_val(k, j);
      assign w_lut[k][j] = LV;
    end
  end

  assign w_en     = ~r_vld_p5 | out_ready;
  assign in_ready = w_en;
  assign w_hi     = HB'(in_data[DW-1:QW]);

  always_comb begin
    for (int i = 0; i < 2 * NP; i++) w_term[i] = '0;
    w_term[0] = r_lo_p1;
    for (int k = 0; k < NC; k++) w_term[k+1] = r_lut_p1[k];
  end

  always_comb begin
    w_sum = '0;
    for (int p = 0; p < NP; p++) w_sum = w_sum + r_ps_p2[p];
  end

  // thresholds rise with m, so the last one passed is the largest m*Q <= S
  always_comb begin
    w_m = '0;
    for (int m = 1; m <= NC + 1; m++)
      if (r_s_p3 >= mq(m)) w_m = QW'(mq(m));
  end

  assign w_full = r_s_p4 - r_m_p4;

  always_ff @(posedge clk) begin
    if (w_en) begin
      // stage 1: LUT lookup of each high-part chunk
      r_lo_p1   <= in_data[QW-1:0];
      for (int k = 0; k < NC; k++) r_lut_p1[k] <= w_lut[k][w_hi[k*CHUNK +: CHUNK]];
      r_mode_p1 <= in_mode;
      r_tag_p1  <= in_tag;
      // stage 2: pairwise partial sums
      for (int p = 0; p < NP; p++) r_ps_p2[p] <= SW'(w_term[2*p]) + SW'(w_term[2*p+1]);
      r_mode_p2 <= r_mode_p1;
      r_tag_p2  <= r_tag_p1;
      // stage 3: final sum
      r_s_p3    <= w_sum;
      r_mode_p3 <= r_mode_p2;
      r_tag_p3  <= r_tag_p2;
      // stage 4: multiple-of-Q selection
      r_m_p4    <= w_m;
      r_s_p4    <= r_s_p3[QW-1:0];
      r_mode_p4 <= r_mode_p3;
      r_tag_p4  <= r_tag_p3;
    end
  end

  // stage 5: residue and control, reset so the outputs read zero after reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld_p1  <= 1'b0;
      r_vld_p2  <= 1'b0;
      r_vld_p3  <= 1'b0;
      r_vld_p4  <= 1'b0;
      r_vld_p5  <= 1'b0;
      r_full_p5 <= '0;
      r_tag_p5  <= '0;
      r_mode_p5 <= 1'b0;
    end else if (w_en) begin
      r_vld_p1  <= in_valid;
      r_vld_p2  <= r_vld_p1;
      r_vld_p3  <= r_vld_p2;
      r_vld_p4  <= r_vld_p3;
      r_vld_p5  <= r_vld_p4;
      r_full_p5 <= w_full;
      r_tag_p5  <= r_tag_p4;
      r_mode_p5 <= r_mode_p4;
    end
  end

  assign out_valid = r_vld_p5;
  assign out_full  = r_full_p5;
  assign out_tag   = r_tag_p5;
  assign out_rnd   = r_vld_p5 ? round_out(r_full_p5, r_mode_p5) : '0;

`ifdef REDUC_RANGECHK_EN
  always_ff @(posedge clk) begin
    if (!rst_n) err_sticky <= 1'b0;
    else if (r_vld_p5 && (r_full_p5 >= Q)) err_sticky <= 1'b1;
  end
`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst_n && r_vld_p5 && (r_full_p5 >= Q))
      $error("mod_reduce_pipe: residue %h not below Q", r_full_p5);
  end
`endif
`endif

endmodule

// File: tb/tb_mod_reduce_pipe.sv
// Table-driven and scoreboarded bench for mod_reduce_pipe (default parameters).
module tb_mod_reduce_pipe;
  localparam int QW  = 49;
  localparam int DW  = 74;
  localparam int TW  = 4;
  localparam int RW1 = 8;
  localparam int NR  = 3000;
  localparam logic [QW-1:0] Q  = 49'h1F41002F80001;
  localparam logic [DW-1:0] QD = {25'b0, Q};

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_mode = 1'b0;
  logic           out_ready = 1'b1;
  logic [DW-1:0]  in_data = '0;
  logic [TW-1:0]  in_tag = '0;
  logic           in_ready, out_valid;
  logic [QW-1:0]  out_full;
  logic [RW1-1:0] out_rnd;
  logic [TW-1:0]  out_tag;
`ifdef REDUC_RANGECHK_EN
  logic           err_sticky;
`endif

  mod_reduce_pipe dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_full(out_full), .out_rnd(out_rnd), .out_tag(out_tag)
`ifdef REDUC_RANGECHK_EN
    , .err_sticky(err_sticky)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [QW-1:0]  full;
    logic [RW1-1:0] rnd;
    logic [TW-1:0]  tag;
  } exp_t;

  typedef struct {
    logic [DW-1:0]  d;
    logic           m;
    logic [TW-1:0]  t;
    logic [QW-1:0]  f;
    logic [RW1-1:0] r;
  } vec_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [QW-1:0] act, input logic [QW-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, req);
    end
  endtask

  function automatic exp_t model(input logic [DW-1:0] d, input logic m, input logic [TW-1:0] t);
    exp_t e;
    logic [DW-1:0] r;
    logic [5:0] h0;
    logic [7:0] h1;
    r = d % QD;
    e.full = QW'(r);
    h0 = e.full[QW-1 -: 6] + 6'd1;
    h1 = e.full[QW-1 -: 8] + 8'd1;
    e.rnd = m ? h1 : {2'b00, h0};
    e.tag = t;
    return e;
  endfunction

  // Called at posedge+1 with inputs set; checks handshake, scoreboards, advances one clock.
  task automatic cycle(input exp_t pe, output bit acc);
    exp_t e;
    #1;
    chk("in_ready", QW'(in_ready), QW'(!(out_valid && !out_ready)));
    acc = in_valid && in_ready;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_out: got tag %0d full %h, want no output", out_tag, out_full);
      end else begin
        e = sb.pop_front();
        chk("out_full", out_full, e.full);
        chk("out_rnd", QW'(out_rnd), QW'(e.rnd));
        chk("out_tag", QW'(out_tag), QW'(e.tag));
      end
    end
    if (acc) sb.push_back(pe);
    @(posedge clk);
    #1;
  endtask

  // Single sample into an empty pipe; counts edges from acceptance until out_valid.
  task automatic lat_check(input logic [DW-1:0] d, input logic m, input logic [TW-1:0] t, input exp_t e);
    int k;
    in_data = d; in_mode = m; in_tag = t; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    k = 1;
    while (!out_valid && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("latency", QW'(k), QW'(5));
    chk("lat_full", out_full, e.full);
    chk("lat_rnd", QW'(out_rnd), QW'(e.rnd));
    chk("lat_tag", QW'(out_tag), QW'(e.tag));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #5000000;
    $display("FAIL timeout: got no finish, want finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[10];
    exp_t pe0;
    bit   acc;
    int   idx, stall, guard, n;
    logic started;
    logic [QW-1:0] held;

    pe0 = '0;
    tbl[0] = '{d: '0,                 m: 1'b1, t: 4'd1,  f: '0,                 r: 8'h01};
    tbl[1] = '{d: QD + 74'd5,         m: 1'b0, t: 4'd2,  f: 49'd5,              r: 8'h01};
    tbl[2] = '{d: QD * 2 - 74'd1,     m: 1'b0, t: 4'd3,  f: 49'h1F41002F80000,  r: 8'h3F};
    tbl[3] = '{d: QD * 2 - 74'd1,     m: 1'b1, t: 4'd4,  f: 49'h1F41002F80000,  r: 8'hFB};
    tbl[4] = '{d: QD * 3,             m: 1'b0, t: 4'd5,  f: '0,                 r: 8'h01};
    tbl[5] = '{d: 74'd1 << 49,        m: 1'b0, t: 4'd6,  f: 49'h00BEFFD07FFFF,  r: 8'h02};
    tbl[6] = '{d: 74'd1 << 49,        m: 1'b1, t: 4'd7,  f: 49'h00BEFFD07FFFF,  r: 8'h06};
    tbl[7] = '{d: QD,                 m: 1'b1, t: 4'd8,  f: '0,                 r: 8'h01};
    tbl[8] = '{d: QD - 74'd1,         m: 1'b0, t: 4'd9,  f: 49'h1F41002F80000,  r: 8'h3F};
    tbl[9] = '{d: QD * 7 + 74'd12,    m: 1'b1, t: 4'd10, f: 49'd12,             r: 8'h01};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", QW'(out_valid), '0);
    chk("rst_full", out_full, '0);
    chk("rst_rnd", QW'(out_rnd), '0);
    chk("rst_tag", QW'(out_tag), '0);
    rst_n = 1'b1;

    lat_check('0, 1'b0, 4'd3, '{full: '0, rnd: 8'd1, tag: 4'd3});

    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_data = tbl[i].d; in_mode = tbl[i].m; in_tag = tbl[i].t;
      cycle('{full: tbl[i].f, rnd: tbl[i].r, tag: tbl[i].t}, acc);
      chk("tbl_accept", QW'(acc), QW'(1));
    end
    in_valid = 1'b0;
    for (int c = 0; c < 20 && sb.size() > 0; c++) cycle(pe0, acc);
    chk("tbl_drain", QW'(sb.size()), '0);

    idx = 0; stall = 0; guard = 0; started = 1'b0; held = '0;
    while ((idx < 8 || sb.size() > 0) && guard < 100) begin
      in_valid = (idx < 8);
      in_data  = {25'(idx + 1), 49'(idx * 12345 + 7)};
      in_mode  = idx[0];
      in_tag   = TW'(idx);
      if (out_valid && !started) begin
        started = 1'b1;
        stall = 3;
        held = out_full;
      end
      out_ready = (stall == 0);
      cycle(model(in_data, in_mode, in_tag), acc);
      if (stall > 0) begin
        chk("stall_hold", out_full, held);
        chk("stall_noacc", QW'(acc), '0);
        stall--;
      end
      if (acc) idx++;
      guard++;
    end
    chk("stall_sent", QW'(idx), QW'(8));
    chk("stall_drain", QW'(sb.size()), '0);

    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = QD * 2 + 74'(i); in_mode = 1'b0; in_tag = TW'(12 + i);
      cycle(model(in_data, in_mode, in_tag), acc);
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sb.delete();
    chk("midrst_valid", QW'(out_valid), '0);
    for (int c = 0; c < 8; c++) cycle(pe0, acc);
    lat_check(74'd1 << 49, 1'b1, 4'd9, '{full: 49'h00BEFFD07FFFF, rnd: 8'd6, tag: 4'd9});

    n = 0; guard = 0;
    while ((n < NR || sb.size() > 0) && guard < NR * 4 + 200) begin
      in_valid  = (n == 0) || ((n < NR) && ($urandom_range(0, 3) != 0));
      in_data   = (n == 0) ? '1 : DW'({$urandom(), $urandom(), $urandom()});
      in_mode   = 1'($urandom());
      in_tag    = TW'($urandom());
      out_ready = 1'($urandom());
      cycle(model(in_data, in_mode, in_tag), acc);
      if (acc) n++;
      guard++;
    end
    in_valid = 1'b0;
    chk("rand_sent", QW'(n), QW'(NR));
    chk("rand_drain", QW'(sb.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
